// File: rtl/task_packet_arbiter_pkg.sv
// rtl/task_packet_arbiter_pkg.sv - shared types and helpers for the task packet arbiter
//
// Purpose: arbiter FSM state encoding and the requester-ID width helper,
// imported by the arbiter top and usable by anything that carries owner IDs.
// Ports: none (package).

package task_packet_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,  // waiting for a first beat to grant
    ST_PASS = 1'b1   // forwarding the body of the granted packet
  } arb_state_t;

  // Width of a requester ID; never narrower than one bit so a 1-requester
  // build still has a legal vector.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/id_fifo.sv
// rtl/id_fifo.sv - owner-ID FIFO tagging task results with their requester
//
// Purpose: holds the requester ID of every granted packet, in grant order,
// until the matching result packet's last beat leaves the task.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (empties the FIFO)
//   push, push_id     write an ID
//   pop               drop the head entry
//   full, empty       occupancy flags
//   head              oldest stored ID (stale when empty)

module id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // legal then; the write lands on the slot being read out this edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/task_packet_arbiter.sv
// rtl/task_packet_arbiter.sv - round-robin packet arbiter in front of a shared task
//
// Purpose: grants whole packets from NUM_REQ requesters to one shared task,
// forwards their beats one cycle later, and tags the task's result packets
// with the owning requester ID in grant order.
// Ports:
//   i_clk, i_rst                         clock, synchronous active-high reset
//   i_req_data/valid/first/last          per-requester beat inputs (slice k = requester k)
//   o_req_ready                          per-requester accept
//   o_task_data/valid/first/last         beat stream to the shared task (registered)
//   i_task_data/valid/last               result stream from the task
//   o_out_data/valid/last, o_out_id      tagged result stream (registered)
//   o_err_timeout/framing/orphan         one-cycle error pulses

module task_packet_arbiter
  import task_packet_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0]              i_req_first,
  input  logic [NUM_REQ-1:0]              i_req_last,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [DATA_WIDTH-1:0]           o_task_data,
  output logic                            o_task_valid,
  output logic                            o_task_first,
  output logic                            o_task_last,
  input  logic [OUT_WIDTH-1:0]            i_task_data,
  input  logic                            i_task_valid,
  input  logic                            i_task_last,
  output logic [OUT_WIDTH-1:0]            o_out_data,
  output logic                            o_out_valid,
  output logic                            o_out_last,
  output logic [id_width(NUM_REQ)-1:0]    o_out_id,
  output logic                            o_err_timeout,
  output logic                            o_err_framing,
  output logic                            o_err_orphan
);

  localparam int IDW = id_width(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [CW-1:0]    stall_q, stall_d;

  logic [NUM_REQ-1:0]    cand;
  logic [NUM_REQ-1:0]    ready;
  logic [IDW:0]          rr_sum;
  logic                  grant_found;
  logic [IDW-1:0]        grant_idx;
  logic                  acc_valid;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  acc_first;
  logic                  acc_last;
  logic                  framing_evt;
  logic                  timeout_evt;
  logic                  orphan_evt;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [IDW-1:0]        fifo_head;

  id_fifo #(
    .WIDTH (IDW),
    .DEPTH (FIFO_DEPTH)
  ) u_id_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push    (fifo_push),
    .push_id (grant_idx),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    stall_d      = stall_q;
    cand         = i_req_valid & i_req_first;
    ready        = '0;
    rr_sum       = '0;
    grant_found  = 1'b0;
    grant_idx    = '0;
    acc_valid    = 1'b0;
    acc_data     = '0;
    acc_first    = 1'b0;
    acc_last     = 1'b0;
    framing_evt  = 1'b0;
    timeout_evt  = 1'b0;
    fifo_push    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Body beats with no packet open are swallowed and flagged; those
        // requesters have first=0 so they are never grant candidates here.
        ready       = i_req_valid & ~i_req_first;
        framing_evt = |ready;

        // Search starts one past the last granted requester and wraps.
        for (int i = 1; i <= NUM_REQ; i++) begin
          rr_sum = {1'b0, last_grant_q} + (IDW+1)'(i);
          if (rr_sum >= (IDW+1)'(NUM_REQ)) begin
            rr_sum = rr_sum - (IDW+1)'(NUM_REQ);
          end
          if (!grant_found && cand[rr_sum[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = rr_sum[IDW-1:0];
          end
        end

        // Full FIFO blocks the grant even if a pop frees a slot this cycle.
        if (grant_found && !fifo_full) begin
          ready[grant_idx] = 1'b1;
          acc_valid        = 1'b1;
          acc_data         = i_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          acc_first        = 1'b1;
          acc_last         = i_req_last[grant_idx];
          fifo_push        = 1'b1;
          last_grant_d     = grant_idx;
          owner_d          = grant_idx;
          stall_d          = '0;
          if (!i_req_last[grant_idx]) begin
            state_d = ST_PASS;
          end
        end
      end

      ST_PASS: begin
        ready[owner_q] = 1'b1;
        if (i_req_valid[owner_q]) begin
          acc_valid   = 1'b1;
          acc_data    = i_req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
          acc_first   = 1'b0;  // a repeated first mid-packet is demoted
          acc_last    = i_req_last[owner_q];
          framing_evt = i_req_first[owner_q];
          stall_d     = '0;
          if (i_req_last[owner_q]) begin
            state_d = ST_IDLE;
          end
        end else if (stall_q == CW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th idle cycle: close the packet for the task.
          timeout_evt = 1'b1;
          acc_valid   = 1'b1;
          acc_last    = 1'b1;
          stall_d     = '0;
          state_d     = ST_IDLE;
        end else begin
          stall_d = stall_q + CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_req_ready = i_rst ? '0 : ready;

  assign fifo_pop   = i_task_valid & i_task_last & ~fifo_empty;
  assign orphan_evt = i_task_valid & fifo_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_q  <= IDW'(NUM_REQ - 1);
      owner_q       <= '0;
      stall_q       <= '0;
      o_task_data   <= '0;
      o_task_valid  <= 1'b0;
      o_task_first  <= 1'b0;
      o_task_last   <= 1'b0;
      o_out_data    <= '0;
      o_out_valid   <= 1'b0;
      o_out_last    <= 1'b0;
      o_out_id      <= '0;
      o_err_timeout <= 1'b0;
      o_err_framing <= 1'b0;
      o_err_orphan  <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      stall_q       <= stall_d;
      o_task_data   <= acc_data;
      o_task_valid  <= acc_valid;
      o_task_first  <= acc_first;
      o_task_last   <= acc_last;
      o_out_data    <= i_task_valid ? i_task_data : '0;
      o_out_valid   <= i_task_valid;
      o_out_last    <= i_task_valid & i_task_last;
      // Head is sampled before this cycle's pop takes effect.
      o_out_id      <= (i_task_valid && !fifo_empty) ? fifo_head : '0;
      o_err_timeout <= timeout_evt;
      o_err_framing <= framing_evt;
      o_err_orphan  <= orphan_evt;
    end
  end

endmodule
